// File: rtl/pipe_bundle_reg.sv
//==============================================================================
// Module      : pipe_bundle_reg
// Description : Inter-stage pipeline register carrying a bundle of LANES
//               instruction slots with per-lane valid bits. Valid/ready
//               handshake, optional skid entry for full throughput with a
//               registered in_ready, global flush and per-lane squash.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_bundle_reg #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int SKID  = 1
) (
  input  logic                   clk,
  input  logic                   resetn,     // synchronous, active-high
  input  logic                   flush,
  input  logic [LANES-1:0]       squash,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready
);

  // Occupancy of the stage; TWO is only reachable when the skid entry exists.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LANES-1:0]       main_v_q, main_v_d;
  logic [LANES-1:0]       skid_v_q, skid_v_d;
  logic [LANES*WIDTH-1:0] main_data_q, main_data_d;
  logic [LANES*WIDTH-1:0] skid_data_q, skid_data_d;

  logic                   main_full;
  logic                   push;
  logic                   pop;
  logic                   kill;
  logic                   head_gone;
  logic [LANES-1:0]       main_v_sq;

  // A held bundle is identified purely by having at least one valid lane.
  assign main_full = |main_v_q;
  assign push      = in_ready & (|in_valid);
  assign pop       = out_ready & main_full;

  // Squash is applied to the head only; if it strips every lane the head is
  // treated as consumed so the skid bundle can move up on the same edge.
  assign main_v_sq = main_v_q & ~squash;
  assign kill      = main_full & ~(|main_v_sq);
  assign head_gone = pop | kill;

  generate
    if (SKID != 0) begin : g_ready_reg
      // Depends only on the state flop: no path from out_ready to in_ready.
      assign in_ready = (state_q != ST_TWO);
    end else begin : g_ready_comb
      assign in_ready = ~main_full | out_ready;
    end
  endgenerate

  assign out_valid = main_v_q;
  assign out_data  = main_data_q;

  // Next-state: remove head (pop or full squash), else partial squash, then append push.
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    state_d     = state_q;

    if (flush) begin
      // Held bundles and any same-cycle push are dropped together.
      main_v_d = '0;
      skid_v_d = '0;
    end else begin
      if (head_gone) begin
        main_v_d = skid_v_q;
        if (|skid_v_q) begin
          main_data_d = skid_data_q;
        end
        skid_v_d = '0;
      end else begin
        main_v_d = main_v_sq;
      end

      if (push) begin
        if (~(|main_v_d)) begin
          main_v_d    = in_valid;
          main_data_d = in_data;
        end else if (SKID != 0) begin
          skid_v_d    = in_valid;
          skid_data_d = in_data;
        end
      end
    end

    if (|skid_v_d) begin
      state_d = ST_TWO;
    end else if (|main_v_d) begin
      state_d = ST_ONE;
    end else begin
      state_d = ST_EMPTY;
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= ST_EMPTY;
      main_v_q    <= '0;
      skid_v_q    <= '0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

`default_nettype wire
